mem_access_unit: RTL

Parametrised load/store unit between the M stage and a request/response (sram-like) data bus. It generates byte strobes and lane-replicated write data for bus widths of 32 or 64 bits, and flags misaligned accesses. It tracks up to DEPTH outstanding accesses in an in-order pending queue, and returns sign/zero-extended, tag-annotated load results one cycle after the bus data phase. Unlike the purely combinational generation before it, it supports pipelined outstanding requests and flush-with-drain.

---
 rtl/mem_access_unit_pkg.sv | 45 ++++
 rtl/mem_access_unit_pend_fifo.sv | 71 +++++++
 rtl/mem_access_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the load/store unit: memory op encoding,
// access-size / signedness decoding, and the pending-queue entry.
package mem_pkg;

  typedef enum logic [3:0] {
    OP_LB   = 4'd0,
    OP_LBU  = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LW   = 4'd4,
    OP_SB   = 4'd5,
    OP_SH   = 4'd6,
    OP_SW   = 4'd7,
    OP_NONE = 4'd8
  } mem_op_e;

  // Lane offset field is sized for the widest supported bus (64 bits).
  localparam int unsigned LO_MAX_W = 3;

  typedef struct packed {
    logic                is_load;
    mem_op_e             op;
    logic [LO_MAX_W-1:0] lo;
    logic                discard;
  } pend_s;

  // 0 = byte, 1 = half, 2 = word
  function automatic logic [1:0] size_of(input mem_op_e op);
    case (op)
      OP_LH, OP_LHU, OP_SH: size_of = 2'd1;
      OP_LW, OP_SW:         size_of = 2'd2;
      default:              size_of = 2'd0;
    endcase
  endfunction

  function automatic logic is_load(input mem_op_e op);
    is_load = (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
              (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_signed(input mem_op_e op);
    is_signed = (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/mem_access_unit_pend_fifo.sv
// In-order pending-access queue. Flush marks every stored entry as discard
// rather than dropping it, so the bus data phases can still be consumed.
module mem_pend_fifo
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  pend_s                  i_entry,
  input  logic [TAG_W-1:0]       i_tag,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output pend_s                  o_head,
  output logic [TAG_W-1:0]       o_head_tag,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  pend_s            r_mem [DEPTH];
  logic [TAG_W-1:0] r_tag [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign w_push     = i_push & ~o_full;
  assign w_pop      = i_pop & ~o_empty;
  assign o_head     = r_mem[r_rd];
  assign o_head_tag = r_tag[r_rd];

  // Entry storage, flush marking, pointers and occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_flush)
        for (int unsigned i = 0; i < DEPTH; i++) r_mem[i].discard <= 1'b1;
      if (w_push) begin
        r_mem[r_wr]         <= i_entry;
        r_mem[r_wr].discard <= i_entry.discard | i_flush;
        r_wr                <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Tag storage needs no reset: it is only read behind a valid count
  always_ff @(posedge clk) begin
    if (w_push) r_tag[r_wr] <= i_tag;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: address checks, byte strobes and lane-replicated store
// data toward a request/response bus, an in-order pending queue, and a
// registered, extended, tag-annotated load response.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_valid,
  input  logic [3:0]          i_req_op,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [31:0]         i_req_wdata,
  input  logic [TAG_W-1:0]    i_req_tag,
  output logic                o_req_ready,
  output logic                o_addr_err_ld,
  output logic                o_addr_err_st,
  input  logic                i_flush,
  output logic                o_data_req,
  output logic                o_data_wr,
  output logic [1:0]          o_data_size,
  output logic [ADDR_W-1:0]   o_data_addr,
  output logic [DATA_W/8-1:0] o_data_wstrb,
  output logic [DATA_W-1:0]   o_data_wdata,
  input  logic                i_data_addr_ok,
  input  logic [DATA_W-1:0]   i_data_rdata,
  input  logic                i_data_data_ok,
  output logic                o_resp_valid,
  output logic [31:0]         o_resp_data,
  output logic [TAG_W-1:0]    o_resp_tag,
  output logic                o_busy,
  output logic                o_proto_err
);

  localparam int unsigned NB   = DATA_W / 8;
  localparam int unsigned LO_W = $clog2(NB);

  mem_op_e                w_op;
  logic                   w_is_load;
  logic                   w_is_store;
  logic [1:0]             w_size;
  logic                   w_mis;
  logic [LO_W-1:0]        w_lo;
  logic [NB-1:0]          w_mask;
  pend_s                  w_entry;
  pend_s                  w_head;
  logic [TAG_W-1:0]       w_head_tag;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_empty;
  logic [31:0]            w_word;
  logic [31:0]            w_ext;

  logic                   r_resp_valid;
  logic [31:0]            r_resp_data;
  logic [TAG_W-1:0]       r_resp_tag;
  logic                   r_proto_err;

  assign w_op       = mem_op_e'(i_req_op);
  assign w_is_load  = is_load(w_op);
  assign w_is_store = (w_op == OP_SB) || (w_op == OP_SH) || (w_op == OP_SW);
  assign w_size     = size_of(w_op);
  assign w_lo       = i_req_addr[LO_W-1:0];

  // Alignment check for the decoded access size
  always_comb begin
    w_mis = 1'b0;
    case (w_size)
      2'd1:    w_mis = i_req_addr[0];
      2'd2:    w_mis = |i_req_addr[1:0];
      default: w_mis = 1'b0;
    endcase
  end

  assign o_addr_err_ld = i_req_valid & w_is_load  & w_mis;
  assign o_addr_err_st = i_req_valid & w_is_store & w_mis;
  assign o_data_req    = i_req_valid & (w_is_load | w_is_store) & ~w_mis &
                         ~w_full & ~i_flush;
  assign o_req_ready   = o_data_req & i_data_addr_ok;
  assign o_data_wr     = w_is_store;
  assign o_data_size   = w_size;
  assign o_data_addr   = i_req_addr;

  // Size mask for the strobe, before lane shifting
  always_comb begin
    w_mask = NB'(1);
    case (w_size)
      2'd1:    w_mask = NB'(3);
      2'd2:    w_mask = NB'(15);
      default: w_mask = NB'(1);
    endcase
  end

  assign o_data_wstrb = w_is_store ? (w_mask << w_lo) : '0;

  // Replicate the store datum across every lane of the bus
  always_comb begin
    o_data_wdata = {(DATA_W/32){i_req_wdata}};
    case (w_op)
      OP_SB:   o_data_wdata = {NB{i_req_wdata[7:0]}};
      OP_SH:   o_data_wdata = {(DATA_W/16){i_req_wdata[15:0]}};
      default: o_data_wdata = {(DATA_W/32){i_req_wdata}};
    endcase
  end

  // Entry pushed on accept; lane offset widened to the package field
  always_comb begin
    w_entry            = '0;
    w_entry.is_load    = w_is_load;
    w_entry.op         = w_op;
    w_entry.lo[LO_W-1:0] = w_lo;
    w_entry.discard    = 1'b0;
  end

  mem_pend_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (o_req_ready),
    .i_entry    (w_entry),
    .i_tag      (i_req_tag),
    .i_pop      (i_data_data_ok),
    .i_flush    (i_flush),
    .o_head     (w_head),
    .o_head_tag (w_head_tag),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign o_busy = |w_count;

  // Lane extraction: the head's lane offset brings its data to bit 0
  assign w_word = 32'(i_data_rdata >> {w_head.lo, 3'b000});

  // Sign or zero extension of the extracted byte/half
  always_comb begin
    w_ext = w_word;
    case (size_of(w_head.op))
      2'd0:    w_ext = is_signed(w_head.op) ? {{24{w_word[7]}}, w_word[7:0]}
                                            : {24'd0, w_word[7:0]};
      2'd1:    w_ext = is_signed(w_head.op) ? {{16{w_word[15]}}, w_word[15:0]}
                                            : {16'd0, w_word[15:0]};
      default: w_ext = w_word;
    endcase
  end

  // Response register and sticky protocol-error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_tag   <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      if (i_data_data_ok) begin
        if (w_empty) begin
          r_proto_err <= 1'b1;
        end else if (w_head.is_load & ~w_head.discard & ~i_flush) begin
          r_resp_valid <= 1'b1;
          r_resp_data  <= w_ext;
          r_resp_tag   <= w_head_tag;
        end
      end
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_resp_tag   = r_resp_tag;
  assign o_proto_err  = r_proto_err;

endmodule
